// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: two-requester round-robin front end for a SPI flash read engine.
// Build option FLASH_ARB_TIMEOUT_EN adds a watchdog that aborts a stalled byte stream.
module flash_read_arbiter #(
    parameter logic [31:0] STARTUP_WAIT = 32'd10000000,
    parameter int          LEN_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [23:0]      addr0,
    input  logic [23:0]      addr1,
    input  logic [LEN_W-1:0] len0,
    input  logic [LEN_W-1:0] len1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             rd_owner,
    output logic             eng_start,
    output logic [23:0]      eng_addr,
    output logic [LEN_W-1:0] eng_len,
    input  logic [7:0]       eng_data,
    input  logic             eng_valid,
    input  logic             eng_done,
    output logic             err
);

    localparam logic [2:0] BOOT     = 3'd0;
    localparam logic [2:0] IDLE     = 3'd1;
    localparam logic [2:0] ISSUE    = 3'd2;
    localparam logic [2:0] STREAM   = 3'd3;
    localparam logic [2:0] COMPLETE = 3'd4;

    logic [2:0]       state;
    logic [32:0]      bootCnt;
    logic [LEN_W-1:0] byteCnt;
    logic             owner;
    logic             lastGnt;

    logic             anyReq;
    logic             pickOne;
    logic [23:0]      winAddr;
    logic [LEN_W-1:0] winLen;
    logic             bootDone;
    logic             inStream;
    logic             takeByte;
    logic             lastByte;
    logic             timeoutHit;
    logic             skipEngine;
    logic             closeNow;

    // Winner selection: a lone requester wins, a tie goes to whoever was not served last
    always_comb begin
        pickOne = 1'b0;
        unique case (1'b1)
            (req0 && req1):  pickOne = ~lastGnt;
            (!req0 && req1): pickOne = 1'b1;
            default:         pickOne = 1'b0;
        endcase
    end

    assign anyReq   = req0 | req1;
    assign winAddr  = pickOne ? addr1 : addr0;
    assign winLen   = pickOne ? len1 : len0;
    assign bootDone = bootCnt > {1'b0, STARTUP_WAIT};
    assign inStream = (state == STREAM);
    assign takeByte = inStream && eng_valid;
    assign lastByte = takeByte && ((byteCnt + LEN_W'(1)) == eng_len);

    // A zero-length request is answered without ever starting the engine
    assign skipEngine = (state == ISSUE) && (eng_len == '0);
    assign closeNow   = skipEngine
                      || (inStream && (eng_done || lastByte || timeoutHit));

`ifdef FLASH_ARB_TIMEOUT_EN
    logic [9:0] idleCnt;

    // The 1024th consecutive silent stream cycle trips the watchdog
    assign timeoutHit = inStream && !eng_valid && (idleCnt == 10'd1023);

    // Count silent stream cycles; any byte or leaving STREAM rearms it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idleCnt <= '0;
        end else if (!inStream || eng_valid) begin
            idleCnt <= '0;
        end else begin
            idleCnt <= idleCnt + 10'd1;
        end
    end

    // Abort strobe travels with the done pulse of the aborted transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= timeoutHit;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign err        = 1'b0;
`endif

    // Sequencer: power-up wait, grant, engine command, byte forwarding, completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            bootCnt   <= '0;
            byteCnt   <= '0;
            owner     <= 1'b0;
            lastGnt   <= 1'b1;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_owner  <= 1'b0;
            eng_start <= 1'b0;
            eng_addr  <= '0;
            eng_len   <= '0;
        end else begin
            eng_start <= 1'b0;
            rd_valid  <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;

            if (takeByte) begin
                rd_data  <= eng_data;
                rd_valid <= 1'b1;
                byteCnt  <= byteCnt + LEN_W'(1);
            end

            if (closeNow) begin
                done0   <= ~owner;
                done1   <= owner;
                gnt0    <= 1'b0;
                gnt1    <= 1'b0;
                lastGnt <= owner;
                state   <= COMPLETE;
            end else begin
                case (state)
                    BOOT: begin
                        if (bootDone) begin
                            bootCnt <= '0;
                            state   <= IDLE;
                        end else begin
                            bootCnt <= bootCnt + 33'd1;
                        end
                    end
                    IDLE: begin
                        if (anyReq) begin
                            owner    <= pickOne;
                            rd_owner <= pickOne;
                            gnt0     <= ~pickOne;
                            gnt1     <= pickOne;
                            eng_addr <= winAddr;
                            eng_len  <= winLen;
                            byteCnt  <= '0;
                            state    <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        eng_start <= 1'b1;
                        state     <= STREAM;
                    end
                    STREAM: begin
                        state <= STREAM;
                    end
                    COMPLETE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= BOOT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb_flash_read_arbiter: scoreboard bench for flash_read_arbiter.
// Stimulus pushes expected events; a negedge monitor pops and compares them.
module tb_flash_read_arbiter;

    localparam int          LEN_W   = 8;
    localparam logic [31:0] WAITCYC = 32'd10;

    localparam int K_GNT   = 0;
    localparam int K_START = 1;
    localparam int K_RD    = 2;
    localparam int K_DONE  = 3;
    localparam int K_ERR   = 4;

    typedef struct packed {
        logic [2:0]  kind;
        logic        owner;
        logic [23:0] addr;
        logic [7:0]  val;
    } ev_t;

    logic             clk;
    logic             rst_n;
    logic             req0, req1;
    logic [23:0]      addr0, addr1;
    logic [LEN_W-1:0] len0, len1;
    logic             gnt0, gnt1, done0, done1;
    logic [7:0]       rd_data;
    logic             rd_valid, rd_owner;
    logic             eng_start;
    logic [23:0]      eng_addr;
    logic [LEN_W-1:0] eng_len;
    logic [7:0]       eng_data;
    logic             eng_valid, eng_done;
    logic             err;

    int  checks = 0;
    int  errors = 0;
    ev_t expQ[$];

    int         engOverride = -1;
    int         engExtra    = 0;
    bit         engNoDone   = 1'b0;
    logic [7:0] engBase     = 8'h00;

    flash_read_arbiter #(
        .STARTUP_WAIT(WAITCYC),
        .LEN_W       (LEN_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req0     (req0),
        .req1     (req1),
        .addr0    (addr0),
        .addr1    (addr1),
        .len0     (len0),
        .len1     (len1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .done0    (done0),
        .done1    (done1),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_owner (rd_owner),
        .eng_start(eng_start),
        .eng_addr (eng_addr),
        .eng_len  (eng_len),
        .eng_data (eng_data),
        .eng_valid(eng_valid),
        .eng_done (eng_done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ev_t mk(input int kind, input logic o,
                               input logic [23:0] a, input logic [7:0] v);
        ev_t e;
        e.kind  = 3'(kind);
        e.owner = o;
        e.addr  = a;
        e.val   = v;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input int kind, input logic o,
                           input logic [23:0] a, input logic [7:0] v);
        expQ.push_back(mk(kind, o, a, v));
    endtask

    task automatic popCheck(input ev_t act, input string name);
        ev_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("FAIL %s: got kind=%0d owner=%0d addr=%0h val=%0h, expected no event",
                     name, act.kind, act.owner, act.addr, act.val);
        end else begin
            e = expQ.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got kind=%0d owner=%0d addr=%0h val=%0h, expected kind=%0d owner=%0d addr=%0h val=%0h",
                         name, act.kind, act.owner, act.addr, act.val,
                         e.kind, e.owner, e.addr, e.val);
            end
        end
    endtask

    // Monitor: every observable output event is matched against the queue
    logic g0q, g1q;
    always @(negedge clk) begin
        if (!rst_n) begin
            g0q = 1'b0;
            g1q = 1'b0;
        end else begin
            check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
            if (gnt0 && !g0q) popCheck(mk(K_GNT, 1'b0, 24'h0, 8'h0), "gnt0_rise");
            if (gnt1 && !g1q) popCheck(mk(K_GNT, 1'b1, 24'h0, 8'h0), "gnt1_rise");
            if (eng_start) popCheck(mk(K_START, 1'b0, eng_addr, eng_len), "eng_start");
            if (rd_valid) popCheck(mk(K_RD, rd_owner, 24'h0, rd_data), "rd_valid");
            if (done0) begin
                popCheck(mk(K_DONE, 1'b0, 24'h0, 8'h0), "done0");
                check("gnt0_low_at_done0", 32'(gnt0), 32'd0);
            end
            if (done1) begin
                popCheck(mk(K_DONE, 1'b1, 24'h0, 8'h0), "done1");
                check("gnt1_low_at_done1", 32'(gnt1), 32'd0);
            end
            if (err) popCheck(mk(K_ERR, 1'b0, 24'h0, 8'h0), "err");
            g0q = gnt0;
            g1q = gnt1;
        end
    end

    // Engine model: on a start command, stream bytes then pulse done
    initial begin
        int n;
        eng_data  = 8'h00;
        eng_valid = 1'b0;
        eng_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && eng_start) begin
                n = (engOverride >= 0) ? engOverride : int'(eng_len) + engExtra;
                for (int i = 0; i < n; i++) begin
                    eng_valid = 1'b1;
                    eng_data  = engBase + 8'(i);
                    @(negedge clk);
                    if (!rst_n) break;
                end
                eng_valid = 1'b0;
                if (!engNoDone && rst_n) begin
                    eng_done = 1'b1;
                    @(negedge clk);
                    eng_done = 1'b0;
                end
            end
        end
    end

    task automatic waitGnt(input bit o, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o ? gnt1 : gnt0) begin
                hit = 1'b1;
                break;
            end
        end
        check(name, 32'(hit), 32'd1);
    endtask

    task automatic waitDone(input bit o, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o ? done1 : done0) begin
                hit = 1'b1;
                break;
            end
        end
        check(name, 32'(hit), 32'd1);
    endtask

    // Counts cycles from reset release to gnt0; req0 rises at cycle 2
    task automatic bootLatency(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 2) req0 = 1'b1;
            if (gnt0) begin
                n = i;
                break;
            end
        end
        check(name, 32'(n), 32'd13);
        @(negedge clk);
        check({name, "_eng_start"}, 32'(eng_start), 32'd1);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = '0;
        addr1 = '0;
        len0  = '0;
        len1  = '0;
        repeat (3) @(negedge clk);

        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_done0", 32'(done0), 32'd0);
        check("rst_done1", 32'(done1), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_eng_addr", 32'(eng_addr), 32'd0);
        check("rst_eng_len", 32'(eng_len), 32'd0);
        check("rst_rd_owner", 32'(rd_owner), 32'd0);

        // Boot wait then a four-byte read for requester 0
        addr0   = 24'h000100;
        len0    = 8'd4;
        engBase = 8'hA1;
        pushExp(K_GNT, 1'b0, 24'h0, 8'h0);
        pushExp(K_START, 1'b0, 24'h000100, 8'd4);
        for (int i = 0; i < 4; i++) pushExp(K_RD, 1'b0, 24'h0, 8'hA1 + 8'(i));
        pushExp(K_DONE, 1'b0, 24'h0, 8'h0);
        rst_n = 1'b1;
        bootLatency("boot_gnt_latency");
        waitDone(1'b0, "xfer1_done0");
        req0 = 1'b0;
        repeat (3) @(negedge clk);

        // Zero-length read for requester 1: done only
        addr1 = 24'h000400;
        len1  = 8'd0;
        pushExp(K_GNT, 1'b1, 24'h0, 8'h0);
        pushExp(K_DONE, 1'b1, 24'h0, 8'h0);
        req1 = 1'b1;
        waitDone(1'b1, "len0_done1");
        req1 = 1'b0;
        repeat (3) @(negedge clk);

        // Both requesters held: grants alternate 0,1,0,1,0,1
        addr0   = 24'h000200;
        len0    = 8'd1;
        addr1   = 24'h000300;
        len1    = 8'd2;
        engBase = 8'h50;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                pushExp(K_GNT, 1'b0, 24'h0, 8'h0);
                pushExp(K_START, 1'b0, 24'h000200, 8'd1);
                pushExp(K_RD, 1'b0, 24'h0, 8'h50);
                pushExp(K_DONE, 1'b0, 24'h0, 8'h0);
            end else begin
                pushExp(K_GNT, 1'b1, 24'h0, 8'h0);
                pushExp(K_START, 1'b0, 24'h000300, 8'd2);
                pushExp(K_RD, 1'b1, 24'h0, 8'h50);
                pushExp(K_RD, 1'b1, 24'h0, 8'h51);
                pushExp(K_DONE, 1'b1, 24'h0, 8'h0);
            end
        end
        req0 = 1'b1;
        req1 = 1'b1;
        dn   = 0;
        for (int i = 0; i < 400 && dn < 6; i++) begin
            @(negedge clk);
            if (done0 || done1) dn++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_done_count", 32'(dn), 32'd6);
        repeat (3) @(negedge clk);

        // Engine over-delivers: only len bytes forwarded
        addr0    = 24'h000500;
        len0     = 8'd2;
        engBase  = 8'hC0;
        engExtra = 1;
        pushExp(K_GNT, 1'b0, 24'h0, 8'h0);
        pushExp(K_START, 1'b0, 24'h000500, 8'd2);
        pushExp(K_RD, 1'b0, 24'h0, 8'hC0);
        pushExp(K_RD, 1'b0, 24'h0, 8'hC1);
        pushExp(K_DONE, 1'b0, 24'h0, 8'h0);
        req0 = 1'b1;
        waitDone(1'b0, "trunc_done0");
        req0 = 1'b0;
        repeat (5) @(negedge clk);
        engExtra = 0;

        // Reset while streaming: no done, full boot wait again
        addr0       = 24'h000600;
        len0        = 8'd8;
        engOverride = 0;
        engNoDone   = 1'b1;
        pushExp(K_GNT, 1'b0, 24'h0, 8'h0);
        pushExp(K_START, 1'b0, 24'h000600, 8'd8);
        req0 = 1'b1;
        waitGnt(1'b0, "stall_gnt0");
        repeat (6) @(negedge clk);
        check("queue_empty_before_reset", 32'(expQ.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst_gnt0", 32'(gnt0), 32'd0);
        check("midrst_done0", 32'(done0), 32'd0);
        check("midrst_rd_valid", 32'(rd_valid), 32'd0);
        check("midrst_eng_start", 32'(eng_start), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        check("midrst_eng_addr", 32'(eng_addr), 32'd0);
        check("midrst_eng_len", 32'(eng_len), 32'd0);
        engOverride = -1;
        engNoDone   = 1'b0;
        engBase     = 8'hD0;
        pushExp(K_GNT, 1'b0, 24'h0, 8'h0);
        pushExp(K_START, 1'b0, 24'h000600, 8'd8);
        for (int i = 0; i < 8; i++) pushExp(K_RD, 1'b0, 24'h0, 8'hD0 + 8'(i));
        pushExp(K_DONE, 1'b0, 24'h0, 8'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bootLatency("reboot_gnt_latency");
        waitDone(1'b0, "reboot_done0");
        req0 = 1'b0;
        repeat (4) @(negedge clk);

`ifdef FLASH_ARB_TIMEOUT_EN
        // One byte then silence: abort 1024 cycles after the last byte
        begin
            int n;
            bit seen;
            addr0       = 24'h000700;
            len0        = 8'd4;
            engBase     = 8'hE0;
            engOverride = 1;
            engNoDone   = 1'b1;
            pushExp(K_GNT, 1'b0, 24'h0, 8'h0);
            pushExp(K_START, 1'b0, 24'h000700, 8'd4);
            pushExp(K_RD, 1'b0, 24'h0, 8'hE0);
            pushExp(K_DONE, 1'b0, 24'h0, 8'h0);
            pushExp(K_ERR, 1'b0, 24'h0, 8'h0);
            req0 = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (rd_valid) begin
                    seen = 1'b1;
                    break;
                end
            end
            check("timeout_first_byte", 32'(seen), 32'd1);
            n = 0;
            for (int i = 1; i <= 1100; i++) begin
                @(negedge clk);
                if (err) begin
                    n = i;
                    break;
                end
            end
            check("timeout_latency", 32'(n), 32'd1024);
            req0        = 1'b0;
            engOverride = -1;
            engNoDone   = 1'b0;
            repeat (4) @(negedge clk);
        end
`endif

        for (int i = 0; i < 50 && expQ.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
